// File: rtl/decoder_pkg.sv
// Shared constants and the code-symbol function for the K=3, rate-1/2 Viterbi decoder and its encoder.
package decoder_pkg;

    localparam int K = 3;
    localparam int NSTATES = 1 << (K - 1);
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;
    localparam int METRIC_W = 6;
    localparam logic [METRIC_W-1:0] INIT_METRIC = 6'd16;

    // Symbol {c1,c0} emitted when bit u enters an encoder whose state is {s1,s0}.
    function automatic logic [1:0] expected_symbol(input logic [1:0] state, input logic u);
        logic [K-1:0] window;
        window = {u, state};
        return {^(window & G1), ^(window & G0)};
    endfunction

endpackage

// File: rtl/decoder_viterbi_acs.sv
// Add-compare-select for one trellis state: picks the cheaper of its two incoming branches.
module viterbi_acs
    import decoder_pkg::*;
(
    input  logic [METRIC_W-1:0] pm0_i,
    input  logic [METRIC_W-1:0] pm1_i,
    input  logic [1:0]          sym0_i,
    input  logic [1:0]          sym1_i,
    input  logic [1:0]          rx_i,
    output logic [METRIC_W:0]   metric_o,
    output logic                decision_o
);

    logic [1:0]        diff0;
    logic [1:0]        diff1;
    logic [METRIC_W:0] sum0;
    logic [METRIC_W:0] sum1;

    // Decision 1 means the s0=1 predecessor won; ties fall to the s0=0 predecessor.
    always_comb begin
        diff0      = rx_i ^ sym0_i;
        diff1      = rx_i ^ sym1_i;
        sum0       = {1'b0, pm0_i} + (METRIC_W + 1)'(diff0[1]) + (METRIC_W + 1)'(diff0[0]);
        sum1       = {1'b0, pm1_i} + (METRIC_W + 1)'(diff1[1]) + (METRIC_W + 1)'(diff1[0]);
        decision_o = (sum1 < sum0);
        metric_o   = decision_o ? sum1 : sum0;
    end

endmodule

// File: rtl/encoder.sv
// Reference convolutional encoder (generators 7,5 octal) feeding the decoder.
module encoder
    import decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       valid_o,
    output logic [1:0] d_out
);

    logic [1:0] state_q;
    logic [1:0] d_out_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= enable_i;
            if (enable_i) begin
                d_out_q <= expected_symbol(state_q, d_in);
                state_q <= {d_in, state_q[1]};
            end
        end
    end

    assign d_out   = d_out_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/decoder.sv
// Hard-decision Viterbi decoder for the K=3 (7,5) code using register-exchange survivors.
module decoder
    import decoder_pkg::*;
#(
    parameter int TB_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] d_in,
    output logic       d_out
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    logic [METRIC_W-1:0] metric_q [NSTATES];
    logic [METRIC_W-1:0] metric_d [NSTATES];
    logic [TB_DEPTH-1:0] surv_q   [NSTATES];
    logic [TB_DEPTH-1:0] surv_d   [NSTATES];
    logic [CNT_W-1:0]    count_q;
    logic                d_out_q;

    logic [METRIC_W:0]   acsMetric [NSTATES];
    logic [NSTATES-1:0]  acsDecision;
    logic [NSTATES-1:0]  outBit;
    logic [METRIC_W:0]   minMetric;
    logic [1:0]          bestState;

    // State n={u,s1} is reached from {s1,0} and {s1,1}; the new bit u is n[1].
    for (genvar n = 0; n < NSTATES; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        viterbi_acs u_acs (
            .pm0_i      (metric_q[P0]),
            .pm1_i      (metric_q[P1]),
            .sym0_i     (expected_symbol(P0, NS[1])),
            .sym1_i     (expected_symbol(P1, NS[1])),
            .rx_i       (d_in),
            .metric_o   (acsMetric[n]),
            .decision_o (acsDecision[n])
        );

        assign surv_d[n] = acsDecision[n] ? {surv_q[P1][TB_DEPTH-2:0], NS[1]}
                                          : {surv_q[P0][TB_DEPTH-2:0], NS[1]};
        assign outBit[n] = acsDecision[n] ? surv_q[P1][TB_DEPTH-1] : surv_q[P0][TB_DEPTH-1];
    end

    always_comb begin
        minMetric = acsMetric[0];
        bestState = 2'd0;
        for (int s = 1; s < NSTATES; s++) begin
            if (acsMetric[s] < minMetric) begin
                minMetric = acsMetric[s];
                bestState = 2'(s);
            end
        end
    end

    // Rebasing on the minimum keeps metrics small enough to never overflow.
    always_comb begin
        for (int s = 0; s < NSTATES; s++) begin
            metric_d[s] = METRIC_W'(acsMetric[s] - minMetric);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSTATES; s++) begin
                metric_q[s] <= (s == 0) ? '0 : INIT_METRIC;
                surv_q[s]   <= '0;
            end
            count_q <= '0;
            d_out_q <= 1'b0;
        end else if (enable) begin
            for (int s = 0; s < NSTATES; s++) begin
                metric_q[s] <= metric_d[s];
                surv_q[s]   <= surv_d[s];
            end
            if (count_q == CNT_W'(TB_DEPTH)) begin
                d_out_q <= outBit[bestState];
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder and encoder: clean, impulse, noisy, gapped, reset and burst-error streams.
module tb_decoder;

    import decoder_pkg::*;

    localparam int TB_DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] d_in = 2'b00;
    logic       dOut;
    logic       encEnable = 1'b0;
    logic       encBit = 1'b0;
    logic       encValid;
    logic [1:0] encOut;

    int         errors = 0;
    int         checks = 0;
    logic       uBits [512];
    logic [1:0] modelState;
    logic [1:0] lastEncOut;
    logic       lastDec;
    logic [1:0] encHist [4];

    decoder #(.TB_DEPTH(TB_DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d_in   (d_in),
        .d_out  (dOut)
    );

    encoder enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (encEnable),
        .d_in     (encBit),
        .valid_o  (encValid),
        .d_out    (encOut)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] modelSymbol(input logic [1:0] s, input logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Reset is asserted away from a clock edge, so the outputs must clear with no edge at all.
    task automatic resetPulse();
        rst       = 1'b0;
        enable    = 1'b0;
        encEnable = 1'b0;
        #2;
        checkOutput("reset d_out", {1'b0, dOut}, 2'b00);
        checkOutput("reset enc d_out", encOut, 2'b00);
        checkOutput("reset enc valid", {1'b0, encValid}, 2'b00);
        @(negedge clk);
        rst        = 1'b1;
        modelState = 2'b00;
        lastDec    = 1'b0;
        lastEncOut = 2'b00;
    endtask

    task automatic applyStimulus(input int n, input int flipMode, input bit gaps, input string name);
        logic [1:0] sym;
        logic [1:0] rx;
        logic       expDec;
        for (int j = 0; j < n; j++) begin
            sym = modelSymbol(modelState, uBits[j]);
            rx  = sym;
            if (flipMode == 1 && (j % 16) == 15) rx = rx ^ 2'b01;
            if (flipMode == 2 && (j == 40 || j == 120)) rx = rx ^ 2'b10;
            if (flipMode == 2 && (j == 41 || j == 121)) rx = rx ^ 2'b01;
            enable    = 1'b1;
            d_in      = rx;
            encEnable = 1'b1;
            encBit    = uBits[j];
            @(posedge clk);
            #1;
            modelState = {uBits[j], modelState[1]};
            expDec = 1'b0;
            if (j >= TB_DEPTH) expDec = uBits[j - TB_DEPTH];
            checkOutput({name, " d_out"}, {1'b0, dOut}, {1'b0, expDec});
            checkOutput({name, " enc d_out"}, encOut, sym);
            checkOutput({name, " enc valid"}, {1'b0, encValid}, 2'b01);
            if (j < 4) encHist[2'(j)] = encOut;
            lastDec    = expDec;
            lastEncOut = sym;
            if (gaps && (j % 10) == 9) begin
                for (int g = 0; g < 3; g++) begin
                    enable    = 1'b0;
                    encEnable = 1'b0;
                    d_in      = ~rx;
                    encBit    = ~uBits[j];
                    @(posedge clk);
                    #1;
                    checkOutput({name, " gap d_out hold"}, {1'b0, dOut}, {1'b0, lastDec});
                    checkOutput({name, " gap enc hold"}, encOut, lastEncOut);
                    checkOutput({name, " gap enc valid"}, {1'b0, encValid}, 2'b00);
                end
            end
        end
        enable    = 1'b0;
        encEnable = 1'b0;
    endtask

    initial begin
        $display("[TB] decoder bench, TB_DEPTH=%0d", TB_DEPTH);
        resetPulse();

        for (int i = 0; i < 512; i++) uBits[i] = 1'b0;
        applyStimulus(64, 0, 1'b0, "zeros");

        resetPulse();
        uBits[0] = 1'b1;
        applyStimulus(64, 0, 1'b0, "impulse");
        checkOutput("impulse enc sym0", encHist[0], 2'b11);
        checkOutput("impulse enc sym1", encHist[1], 2'b10);
        checkOutput("impulse enc sym2", encHist[2], 2'b11);
        checkOutput("impulse enc sym3", encHist[3], 2'b00);

        resetPulse();
        for (int i = 0; i < 512; i++) uBits[i] = 1'($urandom);
        applyStimulus(256, 1, 1'b0, "random");

        resetPulse();
        applyStimulus(256, 1, 1'b1, "gaps");

        resetPulse();
        applyStimulus(100, 1, 1'b0, "prereset");
        resetPulse();
        for (int i = 0; i < 512; i++) uBits[i] = 1'($urandom);
        applyStimulus(128, 1, 1'b0, "postreset");

        resetPulse();
        for (int i = 0; i < 512; i++) uBits[i] = 1'($urandom);
        applyStimulus(200, 2, 1'b0, "adjacent");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
